msu_data_fetch: RTL and testbench



---
 rtl/msu_pkg.sv | 19 +
 rtl/msu_word_buf.sv | 87 ++++++++
 rtl/msu_data_fetch.sv | 189 ++++++++++++++++++
 tb/tb_msu_data_fetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// rtl/msu_pkg.sv - shared FSM state type, word geometry and byte-select helper for the MSU data path
package msu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_CUR,
        ST_FETCH_NXT,
        ST_READY,
        ST_DRAIN
    } msu_state_e;

    localparam int WORD_BYTES = 8;
    localparam int BYTE_BITS  = $clog2(WORD_BYTES);

    function automatic logic [7:0] byte_select(input logic [63:0] word, input logic [2:0] sel);
        return word[8*sel +: 8];
    endfunction

endpackage

// File: rtl/msu_word_buf.sv
// rtl/msu_word_buf.sv - current/next word holding registers, promote, and registered byte output
// Next-word storage exists only when MSU_DATA_PREFETCH_EN is defined.
module msu_word_buf
    import msu_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        clr_i,
    input  logic        inval_cur_i,
    input  logic        load_cur_i,
`ifdef MSU_DATA_PREFETCH_EN
    input  logic        load_nxt_i,
    input  logic        promote_i,
`endif
    input  logic [63:0] wdata_i,
    input  logic [2:0]  byte_sel_i,
    input  logic        oob_i,
    output logic [7:0]  data_o
);

    logic [63:0] cur_word_q, cur_word_d;
    logic        cur_valid_q, cur_valid_d;
    logic [7:0]  data_q, data_d;
`ifdef MSU_DATA_PREFETCH_EN
    logic [63:0] nxt_word_q, nxt_word_d;
    logic        nxt_valid_q, nxt_valid_d;
`endif

    always_comb begin
        cur_word_d  = cur_word_q;
        cur_valid_d = cur_valid_q;
`ifdef MSU_DATA_PREFETCH_EN
        nxt_word_d  = nxt_word_q;
        nxt_valid_d = nxt_valid_q;
`endif
        if (clr_i) begin
            cur_valid_d = 1'b0;
`ifdef MSU_DATA_PREFETCH_EN
            nxt_valid_d = 1'b0;
`endif
        end else begin
            if (inval_cur_i) begin
                cur_valid_d = 1'b0;
            end
            if (load_cur_i) begin
                cur_word_d  = wdata_i;
                cur_valid_d = 1'b1;
            end
`ifdef MSU_DATA_PREFETCH_EN
            if (promote_i) begin
                cur_word_d  = nxt_word_q;
                cur_valid_d = nxt_valid_q;
                nxt_valid_d = 1'b0;
            end
            if (load_nxt_i) begin
                nxt_word_d  = wdata_i;
                nxt_valid_d = 1'b1;
            end
`endif
        end
        // Output follows the next-state word so the byte lands together with the busy drop.
        data_d = (cur_valid_d && !oob_i) ? byte_select(cur_word_d, byte_sel_i) : 8'h00;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_word_q  <= '0;
            cur_valid_q <= 1'b0;
            data_q      <= 8'h00;
`ifdef MSU_DATA_PREFETCH_EN
            nxt_word_q  <= '0;
            nxt_valid_q <= 1'b0;
`endif
        end else begin
            cur_word_q  <= cur_word_d;
            cur_valid_q <= cur_valid_d;
            data_q      <= data_d;
`ifdef MSU_DATA_PREFETCH_EN
            nxt_word_q  <= nxt_word_d;
            nxt_valid_q <= nxt_valid_d;
`endif
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/msu_data_fetch.sv
// rtl/msu_data_fetch.sv - MSU-1 data port responder: seek/req FSM and single-outstanding memory read
// Define MSU_DATA_PREFETCH_EN to enable the next-word prefetch buffer.
module msu_data_fetch
    import msu_pkg::*;
#(
    parameter int MEM_AW = 29
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [31:0]       msu_data_addr,
    input  logic              msu_data_seek,
    input  logic              msu_data_req,
    input  logic [31:0]       file_size,
    output logic [7:0]        msu_data,
    output logic              msu_data_busy,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [63:0]       mem_dout
);

    localparam int IDX_W = 32 - BYTE_BITS;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_ONE = idx_t'(1);
`ifdef MSU_DATA_PREFETCH_EN
    localparam idx_t IDX_TWO = idx_t'(2);
`endif

    msu_state_e        state_q, state_d;
    idx_t              cur_idx_q, cur_idx_d;
    logic              busy_q, busy_d;
    logic              mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

    logic              clr, inval_cur, load_cur;
`ifdef MSU_DATA_PREFETCH_EN
    logic              load_nxt, promote;
`endif
    logic              issue;
    idx_t              issue_idx;

    idx_t              addr_idx;
    logic              boundary, ack_live, arrive, oob;
    logic [63:0]       arr_data;

    function automatic logic past_eof(input idx_t idx, input logic [31:0] fsize);
        return {idx, {BYTE_BITS{1'b0}}} >= fsize;
    endfunction

    assign addr_idx = msu_data_addr[31:BYTE_BITS];
    assign boundary = msu_data_req && (msu_data_addr[BYTE_BITS-1:0] == '0);
    assign ack_live = mem_rd_q & mem_ack;
    // With no read in flight, a fetch state is waiting on a zero-filled word past end of file.
    assign arrive   = mem_rd_q ? mem_ack : 1'b1;
    assign arr_data = mem_rd_q ? mem_dout : 64'd0;
    assign oob      = msu_data_addr >= file_size;

    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        busy_d     = busy_q;
        mem_rd_d   = mem_rd_q & ~mem_ack;
        mem_addr_d = mem_addr_q;
        clr        = 1'b0;
        inval_cur  = 1'b0;
        load_cur   = 1'b0;
`ifdef MSU_DATA_PREFETCH_EN
        load_nxt   = 1'b0;
        promote    = 1'b0;
`endif
        issue      = 1'b0;
        issue_idx  = cur_idx_q;

        if (msu_data_seek) begin
            clr       = 1'b1;
            busy_d    = 1'b1;
            cur_idx_d = addr_idx;
            if (mem_rd_q && !mem_ack) begin
                state_d = ST_DRAIN;
            end else begin
                issue     = 1'b1;
                issue_idx = addr_idx;
                state_d   = ST_FETCH_CUR;
            end
        end else begin
            case (state_q)
                ST_DRAIN: begin
                    if (ack_live) begin
                        issue   = 1'b1;
                        state_d = ST_FETCH_CUR;
                    end
                end
                ST_FETCH_CUR: begin
                    if (arrive) begin
                        load_cur = 1'b1;
                        busy_d   = 1'b0;
`ifdef MSU_DATA_PREFETCH_EN
                        issue     = 1'b1;
                        issue_idx = cur_idx_q + IDX_ONE;
                        state_d   = ST_FETCH_NXT;
`else
                        state_d   = ST_READY;
`endif
                    end
                end
`ifdef MSU_DATA_PREFETCH_EN
                ST_FETCH_NXT: begin
                    if (boundary) begin
                        cur_idx_d = cur_idx_q + IDX_ONE;
                        if (arrive) begin
                            load_cur  = 1'b1;
                            issue     = 1'b1;
                            issue_idx = cur_idx_q + IDX_TWO;
                        end else begin
                            // The in-flight prefetch is now the current word; wait for it as a cur fetch.
                            inval_cur = 1'b1;
                            busy_d    = 1'b1;
                            state_d   = ST_FETCH_CUR;
                        end
                    end else if (arrive) begin
                        load_nxt = 1'b1;
                        state_d  = ST_READY;
                    end
                end
`endif
                ST_READY: begin
                    if (boundary) begin
                        cur_idx_d = cur_idx_q + IDX_ONE;
                        issue     = 1'b1;
`ifdef MSU_DATA_PREFETCH_EN
                        promote   = 1'b1;
                        issue_idx = cur_idx_q + IDX_TWO;
                        state_d   = ST_FETCH_NXT;
`else
                        inval_cur = 1'b1;
                        busy_d    = 1'b1;
                        issue_idx = cur_idx_q + IDX_ONE;
                        state_d   = ST_FETCH_CUR;
`endif
                    end
                end
                default: begin
                end
            endcase
        end

        if (issue) begin
            mem_addr_d = issue_idx[MEM_AW-1:0];
            mem_rd_d   = !past_eof(issue_idx, file_size);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cur_idx_q  <= '0;
            busy_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            busy_q     <= busy_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    msu_word_buf u_word_buf (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .clr_i       (clr),
        .inval_cur_i (inval_cur),
        .load_cur_i  (load_cur),
`ifdef MSU_DATA_PREFETCH_EN
        .load_nxt_i  (load_nxt),
        .promote_i   (promote),
`endif
        .wdata_i     (arr_data),
        .byte_sel_i  (msu_data_addr[2:0]),
        .oob_i       (oob),
        .data_o      (msu_data)
    );

    assign msu_data_busy = busy_q;
    assign mem_rd        = mem_rd_q;
    assign mem_addr      = mem_addr_q;

endmodule

// File: tb/tb_msu_data_fetch.sv
// tb/tb_msu_data_fetch.sv - directed vector bench for msu_data_fetch
module tb_msu_data_fetch;

`ifdef MSU_DATA_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    localparam logic [63:0] W0 = 64'h0706050403020100;
    localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] W2 = 64'h1716151413121110;
    localparam logic [63:0] W8 = 64'h4746454443424140;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] msu_data_addr;
    logic        msu_data_seek;
    logic        msu_data_req;
    logic [31:0] file_size;
    logic [7:0]  msu_data;
    logic        msu_data_busy;
    logic        mem_rd;
    logic [28:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_dout;

    int total = 0;
    int bad   = 0;

    msu_data_fetch #(.MEM_AW(29)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .msu_data_addr (msu_data_addr),
        .msu_data_seek (msu_data_seek),
        .msu_data_req  (msu_data_req),
        .file_size     (file_size),
        .msu_data      (msu_data),
        .msu_data_busy (msu_data_busy),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_dout      (mem_dout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        seek;
        logic        req;
        logic        ack;
        logic [63:0] dout;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_rd;
        logic [28:0] e_maddr;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [31:0] a, input logic s, input logic r, input logic k,
                                input logic [63:0] d, input logic [7:0] ed, input logic eb,
                                input logic er, input logic [28:0] em);
        vec_t v;
        v.addr = a; v.seek = s; v.req = r; v.ack = k; v.dout = d;
        v.e_data = ed; v.e_busy = eb; v.e_rd = er; v.e_maddr = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic b,
                              input logic r, input logic [28:0] m);
        chk({name, " data"}, {56'd0, msu_data}, {56'd0, d});
        chk({name, " busy"}, {63'd0, msu_data_busy}, {63'd0, b});
        chk({name, " rd"}, {63'd0, mem_rd}, {63'd0, r});
        chk({name, " maddr"}, {35'd0, mem_addr}, {35'd0, m});
    endtask

    // One clock with the given inputs; pulses drop right after the edge, address holds.
    task automatic go(input logic [31:0] a, input logic s, input logic r, input logic k,
                      input logic [63:0] d);
        msu_data_addr = a;
        msu_data_seek = s;
        msu_data_req  = r;
        mem_ack       = k;
        mem_dout      = d;
        @(posedge CLK);
        #1;
        msu_data_seek = 1'b0;
        msu_data_req  = 1'b0;
        mem_ack       = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(32'h5, 1, 0, 0, 64'd0, 8'h00, 1, 1, 29'd0);
        vecs[1]  = mk(32'h5, 0, 0, 0, 64'd0, 8'h00, 1, 1, 29'd0);
        vecs[2]  = mk(32'h5, 0, 0, 0, 64'd0, 8'h00, 1, 1, 29'd0);
        vecs[3]  = mk(32'h5, 0, 0, 1, W0, 8'h05, 0, PF, PF ? 29'd1 : 29'd0);
        vecs[4]  = mk(32'h5, 0, 0, 0, 64'd0, 8'h05, 0, PF, PF ? 29'd1 : 29'd0);
        vecs[5]  = mk(32'h5, 0, 0, 1, W1, 8'h05, 0, 0, PF ? 29'd1 : 29'd0);
        vecs[6]  = mk(32'h6, 0, 1, 0, 64'd0, 8'h06, 0, 0, PF ? 29'd1 : 29'd0);
        vecs[7]  = mk(32'h7, 0, 1, 0, 64'd0, 8'h07, 0, 0, PF ? 29'd1 : 29'd0);
        vecs[8]  = mk(32'h8, 0, 1, 0, 64'd0, PF ? 8'h08 : 8'h00, !PF, 1, PF ? 29'd2 : 29'd1);
        vecs[9]  = mk(32'h8, 0, 0, 0, 64'd0, PF ? 8'h08 : 8'h00, !PF, 1, PF ? 29'd2 : 29'd1);
        vecs[10] = mk(32'h8, 0, 0, 1, PF ? W2 : W1, 8'h08, 0, 0, PF ? 29'd2 : 29'd1);

        RST_N = 1'b0;
        msu_data_addr = '0; msu_data_seek = 1'b0; msu_data_req = 1'b0;
        mem_ack = 1'b0; mem_dout = '0; file_size = 32'h100;
        repeat (2) @(posedge CLK);
        #1;
        expect_out("reset", 8'h00, 0, 0, 29'd0);
        RST_N = 1'b1;
        go(32'h0, 0, 0, 0, 64'd0);
        expect_out("idle", 8'h00, 0, 0, 29'd0);

        for (int i = 0; i < 11; i++) begin
            go(vecs[i].addr, vecs[i].seek, vecs[i].req, vecs[i].ack, vecs[i].dout);
            expect_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_busy, vecs[i].e_rd,
                       vecs[i].e_maddr);
        end

        // Slow memory on the word that a boundary req needs next.
        go(32'h5, 1, 0, 0, 64'd0);
        go(32'h5, 0, 0, 0, 64'd0);
        go(32'h5, 0, 0, 1, W0);
        expect_out("slow cur", 8'h05, 0, PF, PF ? 29'd1 : 29'd0);
        go(32'h6, 0, 1, 0, 64'd0);
        go(32'h7, 0, 1, 0, 64'd0);
        expect_out("slow b7", 8'h07, 0, PF, PF ? 29'd1 : 29'd0);
        go(32'h8, 0, 1, 0, 64'd0);
        expect_out("slow cross", 8'h00, 1, 1, 29'd1);
        repeat (20) go(32'h8, 0, 0, 0, 64'd0);
        expect_out("slow wait", 8'h00, 1, 1, 29'd1);
        go(32'h8, 0, 0, 1, W1);
        expect_out("slow fill", 8'h08, 0, PF, PF ? 29'd2 : 29'd1);
        go(32'h8, 0, 0, 1, W2);
        expect_out("slow settle", 8'h08, 0, 0, PF ? 29'd2 : 29'd1);

        // Re-seek with a read in flight; seek and req together act as seek.
        go(32'h0, 1, 1, 0, 64'd0);
        expect_out("seek+req", 8'h00, 1, 1, 29'd0);
        repeat (2) go(32'h0, 0, 0, 0, 64'd0);
        go(32'h40, 1, 0, 0, 64'd0);
        expect_out("reseek", 8'h00, 1, 1, 29'd0);
        repeat (2) go(32'h40, 0, 0, 0, 64'd0);
        go(32'h40, 0, 0, 1, 64'hDEADBEEFCAFEF00D);
        expect_out("stale ack", 8'h00, 1, 1, 29'd8);
        go(32'h40, 0, 0, 0, 64'd0);
        go(32'h40, 0, 0, 1, W8);
        expect_out("word8", 8'h40, 0, PF, PF ? 29'd9 : 29'd8);
        go(32'h40, 0, 0, 1, 64'd0);
        expect_out("word8 settle", 8'h40, 0, 0, PF ? 29'd9 : 29'd8);

        // Short file: bytes past end read as zero and word 1 is never fetched.
        file_size = 32'd6;
        go(32'h4, 1, 0, 0, 64'd0);
        expect_out("eof seek", 8'h00, 1, 1, 29'd0);
        go(32'h4, 0, 0, 1, W0);
        expect_out("eof cur", 8'h04, 0, 0, PF ? 29'd1 : 29'd0);
        go(32'h4, 0, 0, 0, 64'd0);
        go(32'h5, 0, 1, 0, 64'd0);
        expect_out("eof b5", 8'h05, 0, 0, PF ? 29'd1 : 29'd0);
        go(32'h6, 0, 1, 0, 64'd0);
        expect_out("eof b6", 8'h00, 0, 0, PF ? 29'd1 : 29'd0);
        go(32'h7, 0, 1, 0, 64'd0);
        expect_out("eof b7", 8'h00, 0, 0, PF ? 29'd1 : 29'd0);

        // Reset mid-read, then a late ack must be ignored.
        go(32'h0, 1, 0, 0, 64'd0);
        expect_out("pre reset", 8'h00, 1, 1, 29'd0);
        RST_N = 1'b0;
        #1;
        expect_out("async reset", 8'h00, 0, 0, 29'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        go(32'h0, 0, 0, 1, W0);
        expect_out("late ack", 8'h00, 0, 0, 29'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
